bus_rx_port: RTL and testbench
==============================

# bus_rx_port

Receive-side endpoint for one device port of the bus generator/arbiter (`bs_gnrtr_n_rbtr`). It captures the arbiter's `push`/`D_push` strobe, filters packets by destination ID, and buffers accepted packets in a first-word-fall-through FIFO for a local consumer. It is the complement of the transmit FIFO that the arbiter drains through `pndng`/`pop`/`D_pop`. One instance sits on each of the `drvrs` outputs.

## Interface
- `width`, 16: packet size in bits (same as arbiter `pckg_sz`); must be ≥ 9.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `ID`, 0: this port's 8-bit address.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: reset, asynchronous assert, active-low.
- `push`  in  1: arbiter write strobe for this port; cannot be back-pressured.
- `D_push`  in  width: packet; bits [width-1:width-8] hold the destination ID.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `clr_stats`  in  1: synchronous clear of counters and sticky flag.
- `out_valid`  out  1: FIFO not empty (also serves as `pndng` to a downstream consumer).
- `out_data`  out  width: head packet, with the ID field intact.
- `out_bcast`  out  1: head packet carried the broadcast ID 8'hFF.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `rx_cnt`, `drop_cnt`, `misroute_cnt`  out  16 each: saturating statistics counters.
- `overflow`  out  1: sticky; set on any drop.

## Operation
- On each cycle with `push`=1, decode `dest = D_push[width-1 -: 8]`:
  - `dest == ID` or `dest == 8'hFF`: the packet is eligible.
  - Any other value: the packet is not stored and `misroute_cnt` increments.
- An eligible packet is written together with a broadcast tag bit. `rx_cnt` increments.
- If the FIFO is full and no pop occurs in the same cycle, the eligible packet is discarded. `drop_cnt` increments and `overflow` sets. `rx_cnt` does not increment.
- A pop occurs when `out_valid && out_ready`. The head advances.
- Counters saturate at 16'hFFFF and never wrap.
- `clr_stats` zeroes all three counters and `overflow`. If an event coincides with `clr_stats`, the clear wins and the event is not counted.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, so the full/empty decode is `count == DEPTH` / `count == 0`.
- Reset values: pointers 0, `count` 0, `out_valid` 0, `out_data` 0, `out_bcast` 0, all counters 0, `overflow` 0.

## Timing
- Write latency: a packet pushed at edge N has `out_valid`=1 and appears on `out_data` after edge N (visible in cycle N+1) if the FIFO was empty.
- `out_data`/`out_bcast` show the head combinationally from storage. They are stable while `out_valid`=1 and `out_ready`=0.
- Push and pop in the same cycle:
  - Non-empty FIFO: both are performed and `count` is unchanged. This holds even when full, so no drop occurs.
  - Empty FIFO: the pop is ignored because `out_valid`=0, and the push is stored.
- Back-to-back pushes on consecutive cycles are all accepted until full. No bubble cycles are needed.
- `reset` asserted mid-operation clears the FIFO and statistics immediately, independent of `clk`. Contents are lost. After deassertion the first `push` is accepted at the next edge.
- No FSM beyond the FIFO occupancy state. All outputs are registered, except `out_data`/`out_bcast`, which are read from registered storage.

## Structure
- Shared package `bus_pkg`:
  - `BCAST_ID = 8'hFF`.
  - `ID_W = 8`.
  - Function `pkt_dest(pkt)` returning the top `ID_W` bits.
  - Typedef `rx_stats_t` (three 16-bit counters plus the `overflow` flag).
- Sub-module `rx_fifo_mem`: parameterized `width+1`-bit × `DEPTH` storage with pointers and count. It exposes `full`, `empty`, `wr_en`, `rd_en`. The top level holds the ID filter and the statistics.

## Test plan
- Reset, then push `D_push=16'h0012` with `ID=0`:
  - Next cycle: `out_valid`=1, `out_data`=16'h0012, `out_bcast`=0, `rx_cnt`=1.
  - Pop it: `out_valid`=0.
- Push 16'h0534 (dest 5, `ID=0`) → nothing stored, `misroute_cnt`=1, `count`=0.
- Push 16'hFFAB → `out_bcast`=1, `out_data`=16'hFFAB.
- Overflow:
  - Push 9 packets 16'h0000–16'h0008 with `out_ready`=0, `DEPTH`=8 → `count`=8, `drop_cnt`=1, `overflow`=1.
  - Pops then return 0x00..0x07 in order.
- Simultaneous: with the FIFO full, push 16'h0099 while popping → no drop, `count` stays 8, 16'h0099 is last out.
  - Repeat on an empty FIFO → `count`=1.
- Wrap and reset:
  - Stream 20 packets with `out_ready`=1 → order preserved across pointer wrap.
  - Assert `reset` mid-stream → all outputs read 0 before the next `clk` edge.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, types and helpers for bus endpoints
package bus_pkg;

  localparam int ID_W      = 8;
  localparam int STAT_W    = 16;
  localparam int MAX_PKT_W = 64;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  typedef struct packed {
    logic [STAT_W-1:0] rx_cnt;
    logic [STAT_W-1:0] drop_cnt;
    logic [STAT_W-1:0] misroute_cnt;
    logic              overflow;
  } rx_stats_t;

  // Packets narrower than MAX_PKT_W are passed zero-extended with their real width.
  function automatic logic [ID_W-1:0] pkt_dest(input logic [MAX_PKT_W-1:0] pkt,
                                               input int unsigned pkt_w);
    logic [MAX_PKT_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// rtl/rx_fifo_mem.sv - FWFT storage with wrapping pointers and separate occupancy count
module rx_fifo_mem #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_rx_port.sv
// rtl/bus_rx_port.sv - receive endpoint: destination filter, rx FIFO and statistics
module bus_rx_port
  import bus_pkg::*;
#(
  parameter int              width = 16,
  parameter int              DEPTH = 8,
  parameter logic [ID_W-1:0] ID    = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       D_push,
  input  logic                   out_ready,
  input  logic                   clr_stats,
  output logic                   out_valid,
  output logic [width-1:0]       out_data,
  output logic                   out_bcast,
  output logic [$clog2(DEPTH):0] count,
  output logic [STAT_W-1:0]      rx_cnt,
  output logic [STAT_W-1:0]      drop_cnt,
  output logic [STAT_W-1:0]      misroute_cnt,
  output logic                   overflow
);

  logic [MAX_PKT_W-1:0] pkt_ext;
  logic [ID_W-1:0]      dest;
  logic                 is_bcast;
  logic                 eligible;
  logic                 misroute;
  logic                 pop;
  logic                 wr_en;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [width:0]       head;
  rx_stats_t            stats;

  always_comb begin
    pkt_ext              = '0;
    pkt_ext[width-1:0]   = D_push;
  end

  assign dest     = pkt_dest(pkt_ext, width);
  assign is_bcast = (dest == BCAST_ID);
  assign eligible = push && ((dest == ID) || is_bcast);
  assign misroute = push && !eligible;
  assign pop      = !empty && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr_en    = eligible && (!full || pop);
  assign drop     = eligible && full && !pop;

  rx_fifo_mem #(
    .W     (width + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .wr_data ({is_bcast, D_push}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Stale storage is masked so outputs read zero whenever nothing is queued.
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head[width-1:0];
  assign out_bcast = !empty && head[width];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stats <= '0;
    end else if (clr_stats) begin
      stats <= '0;
    end else begin
      if (wr_en)    stats.rx_cnt       <= sat_inc(stats.rx_cnt);
      if (drop)     stats.drop_cnt     <= sat_inc(stats.drop_cnt);
      if (misroute) stats.misroute_cnt <= sat_inc(stats.misroute_cnt);
      if (drop)     stats.overflow     <= 1'b1;
    end
  end

  assign rx_cnt       = stats.rx_cnt;
  assign drop_cnt     = stats.drop_cnt;
  assign misroute_cnt = stats.misroute_cnt;
  assign overflow     = stats.overflow;

endmodule

// File: tb/tb_bus_rx_port.sv
// tb/tb_bus_rx_port.sv - bench for bus_rx_port
module tb_bus_rx_port;

  localparam int         W     = 16;
  localparam int         D     = 8;
  localparam logic [7:0] MY_ID = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic [W-1:0]  D_push = '0;
  logic          out_ready = 1'b0;
  logic          clr_stats = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_bcast;
  logic [3:0]    count;
  logic [15:0]   rx_cnt;
  logic [15:0]   drop_cnt;
  logic [15:0]   misroute_cnt;
  logic          overflow;

  bus_rx_port #(.width(W), .DEPTH(D), .ID(MY_ID)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .D_push       (D_push),
    .out_ready    (out_ready),
    .clr_stats    (clr_stats),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_bcast    (out_bcast),
    .count        (count),
    .rx_cnt       (rx_cnt),
    .drop_cnt     (drop_cnt),
    .misroute_cnt (misroute_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: queue of {bcast, packet}, plain integer statistics.
  logic [W:0] mq[$];
  int         m_rx = 0;
  int         m_drop = 0;
  int         m_mis = 0;
  bit         m_ovf = 0;
  bit         model_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_update();
    bit         was_full;
    bit         do_pop;
    bit         elig;
    logic [7:0] dst;
    was_full = (mq.size() == D);
    do_pop   = (mq.size() != 0) && out_ready;
    dst      = D_push[W-1:W-8];
    elig     = push && (dst == MY_ID || dst == 8'hFF);
    if (clr_stats) begin
      m_rx = 0; m_drop = 0; m_mis = 0; m_ovf = 0;
    end else begin
      if (push && !elig) m_mis = sat(m_mis);
      if (elig && (!was_full || do_pop)) m_rx = sat(m_rx);
      if (elig && was_full && !do_pop) begin
        m_drop = sat(m_drop);
        m_ovf  = 1;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (elig && (!was_full || do_pop)) mq.push_back({dst == 8'hFF, D_push});
  endtask

  task automatic step(input bit p, input logic [W-1:0] d, input bit r, input bit c);
    @(negedge clk);
    #1;
    push = p; D_push = d; out_ready = r; clr_stats = c;
    @(posedge clk);
    if (reset) model_update();
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(mq[0][W-1:0]));
        chk("out_bcast", 64'(out_bcast), 64'(mq[0][W]));
      end
      chk("rx_cnt", 64'(rx_cnt), 64'(m_rx));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("misroute_cnt", 64'(misroute_cnt), 64'(m_mis));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_rx", 64'(rx_cnt), 64'(0));
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_on = 1;

    step(1, 16'h0012, 0, 0);
    #2;
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_data", 64'(out_data), 64'h0012);
    chk("t1_bcast", 64'(out_bcast), 64'(0));
    chk("t1_rx", 64'(rx_cnt), 64'(1));
    step(0, '0, 1, 0);
    #2;
    chk("t1_popped", 64'(out_valid), 64'(0));

    step(1, 16'h0534, 0, 0);
    #2;
    chk("mis_cnt", 64'(misroute_cnt), 64'(1));
    chk("mis_count", 64'(count), 64'(0));

    step(1, 16'hFFAB, 0, 0);
    #2;
    chk("bc_flag", 64'(out_bcast), 64'(1));
    chk("bc_data", 64'(out_data), 64'hFFAB);
    step(0, '0, 1, 0);

    step(0, '0, 0, 1);
    #2;
    chk("clr_rx", 64'(rx_cnt), 64'(0));
    for (int i = 0; i < 9; i++) step(1, 16'(i), 0, 0);
    #2;
    chk("ovf_count", 64'(count), 64'(8));
    chk("ovf_drop", 64'(drop_cnt), 64'(1));
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_head", 64'(out_data), 64'h0000);

    step(1, 16'h0099, 1, 0);
    #2;
    chk("sim_count", 64'(count), 64'(8));
    chk("sim_drop", 64'(drop_cnt), 64'(1));
    for (int i = 1; i < 8; i++) begin
      chk("order", 64'(out_data), 64'(i));
      step(0, '0, 1, 0);
      #2;
    end
    chk("sim_last", 64'(out_data), 64'h0099);
    step(0, '0, 1, 0);
    #2;
    chk("drained", 64'(count), 64'(0));

    step(1, 16'h0099, 1, 0);
    #2;
    chk("sim_empty", 64'(count), 64'(1));
    step(0, '0, 1, 0);

    for (int i = 0; i < 20; i++) step(1, 16'(16'h0020 + i), 1, 0);
    #2;
    chk("wrap_count", 64'(count), 64'(1));
    chk("wrap_data", 64'(out_data), 64'h0033);

    for (int i = 0; i < 3; i++) step(1, 16'(16'h0040 + i), 0, 0);
    #2;
    reset = 1'b0;
    push = 1'b0;
    model_on = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_data", 64'(out_data), 64'(0));
    chk("arst_bcast", 64'(out_bcast), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_rx", 64'(rx_cnt), 64'(0));
    chk("arst_drop", 64'(drop_cnt), 64'(0));
    chk("arst_mis", 64'(misroute_cnt), 64'(0));
    chk("arst_ovf", 64'(overflow), 64'(0));
    mq.delete();
    m_rx = 0; m_drop = 0; m_mis = 0; m_ovf = 0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_on = 1;
    step(1, 16'h0012, 0, 0);
    #2;
    chk("post_rst", 64'(count), 64'(1));

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] dst;
      int         sel;
      sel = $urandom_range(0, 3);
      dst = (sel == 1) ? 8'hFF : (sel == 2) ? 8'($urandom) : MY_ID;
      step($urandom_range(0, 3) != 0, {dst, 8'($urandom)},
           $urandom_range(0, 9) < ((n / 200) % 2 == 0 ? 3 : 8),
           $urandom_range(0, 199) == 0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
